// File: rtl/bp_pkg.sv
// Shared branch-op encoding, counter states and outcome resolution for the predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bp_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_JUMP = 2'd3
    } br_op_e;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_state_e;

    // Same decision branch_ctrl makes in execute; validity is applied by the caller.
    function automatic logic resolve_branch(input logic [1:0] op, input logic alu_zero);
        logic taken;
        taken = 1'b0;
        case (op)
            BR_EQ:   taken = alu_zero;
            BR_NE:   taken = ~alu_zero;
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// One 2-bit saturating taken/not-taken counter.
// Latency: state moves one step on the rising edge after en.
// Backpressure: none; en is the only qualifier, holding it low freezes the counter.
module bp_sat_counter2
    import bp_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_STATE;
        end else if (en) begin
            if (taken && (state != ST)) begin
                state <= state + 2'd1;
            end else if (!taken && (state != SNT)) begin
                state <= state - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit counter branch predictor: decode-stage lookup, execute-stage resolve/update, stats.
// Latency: pred_taken/branch/mispredict combinational; table and stats update next edge.
// Backpressure: ex_stall holds off table and statistics updates until the stall drops.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         IDX_BITS   = 4,
    parameter int         PC_WIDTH   = 32,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [PC_WIDTH-1:0]   dec_pc,
    input  logic [1:0]            dec_branch_op,
    output logic                  pred_taken,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [1:0]            ex_branch_op,
    input  logic                  ex_alu_zero,
    input  logic                  ex_pred_taken,
    output logic                  branch,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispred_count
);

    localparam int NUM_ENTRIES = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] dec_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [1:0]          ctr_state [NUM_ENTRIES];
    logic                ex_is_cond;
    logic                stat_en;
    logic                upd_en;
    logic                unused_pc_bits;

    // Word-aligned instructions: the low two PC bits carry no index information.
    assign dec_idx = dec_pc[IDX_BITS+1:2];
    assign ex_idx  = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{dec_pc[PC_WIDTH-1:IDX_BITS+2], dec_pc[1:0],
                              ex_pc[PC_WIDTH-1:IDX_BITS+2], ex_pc[1:0]};

    always_comb begin
        pred_taken = 1'b0;
        if (dec_valid) begin
            case (dec_branch_op)
                BR_EQ, BR_NE: pred_taken = ctr_state[dec_idx][1];
                BR_JUMP:      pred_taken = 1'b1;
                default:      pred_taken = 1'b0;
            endcase
        end
    end

    assign branch     = ex_valid & resolve_branch(ex_branch_op, ex_alu_zero);
    assign mispredict = ex_valid & (ex_branch_op != BR_NONE) & (branch != ex_pred_taken);

    assign ex_is_cond = (ex_branch_op == BR_EQ) || (ex_branch_op == BR_NE);
    assign stat_en    = ex_valid & ~ex_stall;
    assign upd_en     = stat_en & ex_is_cond;

    // No read bypass: a same-cycle write to the decode index shows up one cycle later.
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        bp_sat_counter2 #(
            .INIT_STATE(INIT_STATE)
        ) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (upd_en && (ex_idx == IDX_BITS'(i))),
            .taken (branch),
            .state (ctr_state[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (stat_en) begin
            if (ex_is_cond && (branch_count != {STAT_WIDTH{1'b1}})) begin
                branch_count <= branch_count + 1'b1;
            end
            if (mispredict && (mispred_count != {STAT_WIDTH{1'b1}})) begin
                mispred_count <= mispred_count + 1'b1;
            end
        end
    end

endmodule
